// File: rtl/fp32_pkg.sv
// Shared FP32 constants, field widths and adder state encodings.
// Used by fp32_adder, fp32_unpack and multiplier_fp32.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int WIDE_W = 27;
  localparam int SUM_W  = 28;
  localparam int E_W    = 10;

  localparam logic signed [E_W-1:0] FP32_BIAS = 10'sd127;
  localparam logic signed [E_W-1:0] EXP_MIN   = -10'sd126;
  localparam logic signed [E_W-1:0] EXP_MAX   = 10'sd127;

  localparam logic [31:0] CANON_NAN_DEFAULT   = 32'hFFC0_0000;
  localparam int          ALIGN_LIMIT_DEFAULT = 26;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    UNPACK  = 4'd1,
    SPECIAL = 4'd2,
    ALIGN   = 4'd3,
    ADD_0   = 4'd4,
    ADD_1   = 4'd5,
    NORM    = 4'd6,
    ROUND   = 4'd7,
    PACK    = 4'd8,
    PUT_Z   = 4'd9
  } add_state_t;

endpackage

// File: rtl/fp32_unpack.sv
// Combinational split of an FP32 word into sign, unbiased exponent,
// raw mantissa and class flags.
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0]             data,
  output logic                    s,
  output logic signed [E_W-1:0]   e,
  output logic [MANT_W-1:0]       m,
  output logic                    is_nan,
  output logic                    is_inf,
  output logic                    is_zero,
  output logic                    is_denorm
);

  logic [EXP_W-1:0]  exp_s;
  logic [FRAC_W-1:0] frac_s;

  assign exp_s     = data[30:23];
  assign frac_s    = data[22:0];
  assign s         = data[31];
  assign e         = $signed({2'b00, exp_s}) - FP32_BIAS;
  assign m         = {1'b0, frac_s};
  assign is_nan    = (exp_s == 8'hFF) && (frac_s != 23'd0);
  assign is_inf    = (exp_s == 8'hFF) && (frac_s == 23'd0);
  assign is_zero   = (exp_s == 8'h00) && (frac_s == 23'd0);
  assign is_denorm = (exp_s == 8'h00) && (frac_s != 23'd0);

endmodule

// File: rtl/fp32_adder.sv
// Multi-cycle IEEE-754 single-precision adder, round-to-nearest-even, with denormals.
// Defining FP32_ADD_SUB_EN adds port add_sub_op (1 -> compute A-B).
module fp32_adder
  import fp32_pkg::*;
#(
  parameter logic [31:0] CANON_NAN   = CANON_NAN_DEFAULT,
  parameter int          ALIGN_LIMIT = ALIGN_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic        add_input_STB,
`ifdef FP32_ADD_SUB_EN
  input  logic        add_sub_op,
`endif
  output logic        add_BUSY,
  output logic [31:0] output_sum,
  output logic        add_output_STB,
  input  logic        output_module_BUSY
);

  localparam logic signed [E_W:0] ALIGN_LIM_S = 11'(ALIGN_LIMIT);

  add_state_t state_r, state_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              stb_r, stb_nxt_s;
  logic [31:0]       sum_out_r, sum_out_nxt_s;
  logic [31:0]       a_r, a_nxt_s, b_r, b_nxt_s, z_r, z_nxt_s;
  logic              a_s_r, a_s_nxt_s, b_s_r, b_s_nxt_s, z_s_r, z_s_nxt_s;
  logic signed [E_W-1:0] a_e_r, a_e_nxt_s, b_e_r, b_e_nxt_s, z_e_r, z_e_nxt_s;
  logic [WIDE_W-1:0] a_m_r, a_m_nxt_s, b_m_r, b_m_nxt_s;
  logic [SUM_W-1:0]  sum_r, sum_nxt_s;
  logic [MANT_W-1:0] z_m_r, z_m_nxt_s;
  logic              g_r, g_nxt_s, rb_r, rb_nxt_s, st_r, st_nxt_s;

  logic [31:0]       b_in_s;
  logic signed [E_W:0] diff_ab_s, diff_ba_s;
  logic [EXP_W-1:0]  exp_field_s;

  logic                  ua_s, ub_s, ua_nan, ub_nan, ua_inf, ub_inf;
  logic                  ua_zero, ub_zero, ua_denorm, ub_denorm;
  logic signed [E_W-1:0] ua_e, ub_e;
  logic [MANT_W-1:0]     ua_m, ub_m;

`ifdef FP32_ADD_SUB_EN
  assign b_in_s = {input_b[31] ^ add_sub_op, input_b[30:0]};
`else
  assign b_in_s = input_b;
`endif

  assign diff_ab_s   = {a_e_r[E_W-1], a_e_r} - {b_e_r[E_W-1], b_e_r};
  assign diff_ba_s   = {b_e_r[E_W-1], b_e_r} - {a_e_r[E_W-1], a_e_r};
  assign exp_field_s = 8'(z_e_r + FP32_BIAS);

  fp32_unpack u_unpack_a (
    .data(a_r), .s(ua_s), .e(ua_e), .m(ua_m), .is_nan(ua_nan),
    .is_inf(ua_inf), .is_zero(ua_zero), .is_denorm(ua_denorm)
  );

  fp32_unpack u_unpack_b (
    .data(b_r), .s(ub_s), .e(ub_e), .m(ub_m), .is_nan(ub_nan),
    .is_inf(ub_inf), .is_zero(ub_zero), .is_denorm(ub_denorm)
  );

  // Next-state and datapath update for every FSM state.
  always_comb begin
    state_nxt_s   = state_r;
    busy_nxt_s    = busy_r;
    stb_nxt_s     = stb_r;
    sum_out_nxt_s = sum_out_r;
    a_nxt_s = a_r;     b_nxt_s = b_r;     z_nxt_s = z_r;
    a_s_nxt_s = a_s_r; b_s_nxt_s = b_s_r; z_s_nxt_s = z_s_r;
    a_e_nxt_s = a_e_r; b_e_nxt_s = b_e_r; z_e_nxt_s = z_e_r;
    a_m_nxt_s = a_m_r; b_m_nxt_s = b_m_r; z_m_nxt_s = z_m_r;
    sum_nxt_s = sum_r;
    g_nxt_s = g_r; rb_nxt_s = rb_r; st_nxt_s = st_r;

    case (state_r)
      IDLE: begin
        if (!busy_r && add_input_STB) begin
          a_nxt_s     = input_a;
          b_nxt_s     = b_in_s;
          busy_nxt_s  = 1'b1;
          state_nxt_s = UNPACK;
        end else begin
          busy_nxt_s  = 1'b0;
        end
      end
      UNPACK: begin
        a_s_nxt_s = ua_s; a_e_nxt_s = ua_e; a_m_nxt_s = {ua_m, 3'b000};
        b_s_nxt_s = ub_s; b_e_nxt_s = ub_e; b_m_nxt_s = {ub_m, 3'b000};
        state_nxt_s = SPECIAL;
      end
      SPECIAL: begin
        state_nxt_s = PUT_Z;
        if (ua_nan || ub_nan) begin
          z_nxt_s = CANON_NAN;
        end else if (ua_inf && ub_inf && (a_s_r != b_s_r)) begin
          z_nxt_s = CANON_NAN;
        end else if (ua_inf) begin
          z_nxt_s = a_r;
        end else if (ub_inf) begin
          z_nxt_s = b_r;
        end else if (ua_zero && ub_zero) begin
          z_nxt_s = {a_s_r & b_s_r, 31'd0};
        end else if (ua_zero) begin
          z_nxt_s = b_r;
        end else if (ub_zero) begin
          z_nxt_s = a_r;
        end else begin
          // Denormals keep the minimum exponent and no hidden bit.
          if (ua_denorm) a_e_nxt_s = EXP_MIN;
          else           a_m_nxt_s[26] = 1'b1;
          if (ub_denorm) b_e_nxt_s = EXP_MIN;
          else           b_m_nxt_s[26] = 1'b1;
          state_nxt_s = ALIGN;
        end
      end
      ALIGN: begin
        if (diff_ab_s > 11'sd0) begin
          if (diff_ab_s > ALIGN_LIM_S) begin
            b_m_nxt_s = 27'd1;
            b_e_nxt_s = a_e_r;
          end else begin
            b_m_nxt_s = {1'b0, b_m_r[26:2], b_m_r[1] | b_m_r[0]};
            b_e_nxt_s = b_e_r + 10'sd1;
          end
        end else if (diff_ba_s > 11'sd0) begin
          if (diff_ba_s > ALIGN_LIM_S) begin
            a_m_nxt_s = 27'd1;
            a_e_nxt_s = b_e_r;
          end else begin
            a_m_nxt_s = {1'b0, a_m_r[26:2], a_m_r[1] | a_m_r[0]};
            a_e_nxt_s = a_e_r + 10'sd1;
          end
        end else begin
          state_nxt_s = ADD_0;
        end
      end
      ADD_0: begin
        z_e_nxt_s   = a_e_r;
        state_nxt_s = ADD_1;
        if (a_s_r == b_s_r) begin
          sum_nxt_s = {1'b0, a_m_r} + {1'b0, b_m_r};
          z_s_nxt_s = a_s_r;
        end else if (a_m_r >= b_m_r) begin
          sum_nxt_s = {1'b0, a_m_r - b_m_r};
          z_s_nxt_s = (a_m_r == b_m_r) ? 1'b0 : a_s_r;
        end else begin
          sum_nxt_s = {1'b0, b_m_r - a_m_r};
          z_s_nxt_s = b_s_r;
        end
      end
      ADD_1: begin
        state_nxt_s = NORM;
        if (sum_r[27]) begin
          z_m_nxt_s = sum_r[27:4];
          g_nxt_s   = sum_r[3];
          rb_nxt_s  = sum_r[2];
          st_nxt_s  = sum_r[1] | sum_r[0];
          z_e_nxt_s = z_e_r + 10'sd1;
        end else begin
          z_m_nxt_s = sum_r[26:3];
          g_nxt_s   = sum_r[2];
          rb_nxt_s  = sum_r[1];
          st_nxt_s  = sum_r[0];
        end
      end
      NORM: begin
        if (!z_m_r[23] && (z_e_r > EXP_MIN)) begin
          z_m_nxt_s = {z_m_r[22:0], g_r};
          g_nxt_s   = rb_r;
          rb_nxt_s  = 1'b0;
          z_e_nxt_s = z_e_r - 10'sd1;
        end else begin
          state_nxt_s = ROUND;
        end
      end
      ROUND: begin
        state_nxt_s = PACK;
        if (g_r && (rb_r || st_r || z_m_r[0])) begin
          if (z_m_r == 24'hFF_FFFF) begin
            z_m_nxt_s = 24'h80_0000;
            z_e_nxt_s = z_e_r + 10'sd1;
          end else begin
            z_m_nxt_s = z_m_r + 24'd1;
          end
        end else begin
          z_m_nxt_s = z_m_r;
        end
      end
      PACK: begin
        state_nxt_s = PUT_Z;
        if (z_e_r > EXP_MAX) begin
          z_nxt_s = {z_s_r, 8'hFF, 23'd0};
        end else if ((z_e_r == EXP_MIN) && !z_m_r[23]) begin
          z_nxt_s = {z_s_r, 8'h00, z_m_r[22:0]};
        end else begin
          z_nxt_s = {z_s_r, exp_field_s, z_m_r[22:0]};
        end
      end
      PUT_Z: begin
        // busy_r stays set here; IDLE clears it one edge after the transfer.
        if (stb_r && !output_module_BUSY) begin
          stb_nxt_s   = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          stb_nxt_s     = 1'b1;
          sum_out_nxt_s = z_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; rst aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE; busy_r <= 1'b0; stb_r <= 1'b0; sum_out_r <= 32'd0;
      a_r <= 32'd0; b_r <= 32'd0; z_r <= 32'd0;
      a_s_r <= 1'b0; b_s_r <= 1'b0; z_s_r <= 1'b0;
      a_e_r <= 10'sd0; b_e_r <= 10'sd0; z_e_r <= 10'sd0;
      a_m_r <= 27'd0; b_m_r <= 27'd0; z_m_r <= 24'd0; sum_r <= 28'd0;
      g_r <= 1'b0; rb_r <= 1'b0; st_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s; busy_r <= busy_nxt_s; stb_r <= stb_nxt_s;
      sum_out_r <= sum_out_nxt_s;
      a_r <= a_nxt_s; b_r <= b_nxt_s; z_r <= z_nxt_s;
      a_s_r <= a_s_nxt_s; b_s_r <= b_s_nxt_s; z_s_r <= z_s_nxt_s;
      a_e_r <= a_e_nxt_s; b_e_r <= b_e_nxt_s; z_e_r <= z_e_nxt_s;
      a_m_r <= a_m_nxt_s; b_m_r <= b_m_nxt_s; z_m_r <= z_m_nxt_s;
      sum_r <= sum_nxt_s;
      g_r <= g_nxt_s; rb_r <= rb_nxt_s; st_r <= st_nxt_s;
    end
  end

  assign add_BUSY       = busy_r;
  assign add_output_STB = stb_r;
  assign output_sum     = sum_out_r;

endmodule

// File: tb/tb_fp32_adder.sv
// Scoreboard bench for fp32_adder: results, latency, stall, reset abort, busy-ignore.
module tb_fp32_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] input_a = 32'd0;
  logic [31:0] input_b = 32'd0;
  logic        add_input_STB = 1'b0;
  logic        output_module_BUSY = 1'b0;
  logic        add_BUSY;
  logic [31:0] output_sum;
  logic        add_output_STB;
`ifdef FP32_ADD_SUB_EN
  logic        add_sub_op = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    int          lat;
  } vec_t;

  always #5 clk = ~clk;

  fp32_adder dut (
    .clk(clk),
    .rst(rst),
    .input_a(input_a),
    .input_b(input_b),
    .add_input_STB(add_input_STB),
`ifdef FP32_ADD_SUB_EN
    .add_sub_op(add_sub_op),
`endif
    .add_BUSY(add_BUSY),
    .output_sum(output_sum),
    .add_output_STB(add_output_STB),
    .output_module_BUSY(output_module_BUSY)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sub);
    int guard = 0;
    while (add_BUSY && guard < 500) begin
      @(posedge clk); #1; guard++;
    end
    @(negedge clk);
    input_a = a;
    input_b = b;
`ifdef FP32_ADD_SUB_EN
    add_sub_op = sub;
`endif
    add_input_STB = 1'b1;
    @(posedge clk); #1;
    add_input_STB = 1'b0;
  endtask

  task automatic wait_out(output int lat, output logic [31:0] got, output bit timed_out);
    lat = 0;
    while (!add_output_STB && lat < 2000) begin
      @(posedge clk); #1; lat++;
    end
    timed_out = !add_output_STB;
    got = output_sum;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (add_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", add_BUSY); end
    checks++; if (add_output_STB !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", add_output_STB); end
    checks++; if (output_sum !== 32'd0) begin errors++; $display("FAIL reset_sum: got %h expected 00000000", output_sum); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    vec_t v [$];
    int lat; logic [31:0] got; logic [31:0] e; bit to;
    v.push_back('{a:32'h3F800000, b:32'hBF800000, z:32'h00000000, lat:135});
    v.push_back('{a:32'h7F800000, b:32'hFF800000, z:32'hFFC00000, lat:3});
    v.push_back('{a:32'h7FC00001, b:32'h3F800000, z:32'hFFC00000, lat:3});
    v.push_back('{a:32'h7F800000, b:32'h3F800000, z:32'h7F800000, lat:3});
    v.push_back('{a:32'h80000000, b:32'h80000000, z:32'h80000000, lat:3});
    v.push_back('{a:32'h00000000, b:32'h80000000, z:32'h00000000, lat:3});
    v.push_back('{a:32'h3F800000, b:32'h00000000, z:32'h3F800000, lat:3});
    v.push_back('{a:32'h7F7FFFFF, b:32'h7F7FFFFF, z:32'h7F800000, lat:9});
    v.push_back('{a:32'h00000001, b:32'h00000001, z:32'h00000002, lat:9});
    v.push_back('{a:32'h00800000, b:32'h80000001, z:32'h007FFFFF, lat:9});
    v.push_back('{a:32'h3F800000, b:32'h33800000, z:32'h3F800000, lat:33});
    v.push_back('{a:32'h3F800000, b:32'h33800001, z:32'h3F800001, lat:33});
    v.push_back('{a:32'h3F800000, b:32'h0D800000, z:32'h3F800000, lat:10});
    v.push_back('{a:32'h40000000, b:32'hBF800000, z:32'h3F800000, lat:11});
    v.push_back('{a:32'h40400000, b:32'h3F800000, z:32'h40800000, lat:10});
    foreach (v[i]) begin
      exp_q.push_back(v[i].z);
      launch(v[i].a, v[i].b, 1'b0);
      wait_out(lat, got, to);
      e = exp_q.pop_front();
      checks++;
      if (to) begin errors++; $display("FAIL vec%0d_timeout: no STB, expected %h", i, e); end
      else if (got !== e) begin errors++; $display("FAIL vec%0d_sum: %h+%h got %h expected %h", i, v[i].a, v[i].b, got, e); end
      checks++;
      if (lat != v[i].lat) begin errors++; $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, v[i].lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    int lat; logic [31:0] got; logic [31:0] e; bit to; int extra;
    output_module_BUSY = 1'b1;
    exp_q.push_back(32'h40400000);
    launch(32'h3F800000, 32'h40000000, 1'b0);
    wait_out(lat, got, to);
    e = exp_q.pop_front();
    checks++;
    if (to || got !== e) begin errors++; $display("FAIL stall_sum: got %h expected %h", got, e); end
    checks++;
    if (lat != 10) begin errors++; $display("FAIL stall_latency: got %0d expected 10", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (add_output_STB !== 1'b1 || output_sum !== e) begin
        errors++; $display("FAIL stall_hold%0d: stb %b sum %h expected stb 1 sum %h", i, add_output_STB, output_sum, e);
      end
    end
    @(negedge clk);
    output_module_BUSY = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (add_output_STB !== 1'b0 || add_BUSY !== 1'b1) begin
      errors++; $display("FAIL stall_xfer: stb %b busy %b expected stb 0 busy 1", add_output_STB, add_BUSY);
    end
    @(posedge clk); #1;
    checks++;
    if (add_BUSY !== 1'b0) begin errors++; $display("FAIL stall_busy_drop: got %b expected 0", add_BUSY); end
    extra = 0;
    repeat (8) begin @(posedge clk); #1; if (add_output_STB) extra++; end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL stall_single_xfer: extra STB cycles %0d expected 0", extra); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] got; logic [31:0] e; bit to; int seen;
    launch(32'h3F800000, 32'h33800000, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (add_BUSY !== 1'b0 || add_output_STB !== 1'b0) begin
      errors++; $display("FAIL abort_state: busy %b stb %b expected 0 0", add_BUSY, add_output_STB);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (add_output_STB) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_output: STB cycles %0d expected 0", seen); end
    exp_q.push_back(32'h40800000);
    launch(32'h40000000, 32'h40000000, 1'b0);
    wait_out(lat, got, to);
    e = exp_q.pop_front();
    checks++;
    if (to || got !== e) begin errors++; $display("FAIL abort_next_op: got %h expected %h", got, e); end
    checks++;
    if (lat != 9) begin errors++; $display("FAIL abort_next_latency: got %0d expected 9", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore();
    int lat; logic [31:0] got; logic [31:0] e; bit to; int seen;
    exp_q.push_back(32'h40400000);
    launch(32'h3F800000, 32'h40000000, 1'b0);
    @(negedge clk);
    input_a = 32'h7F800000;
    input_b = 32'h00000001;
    add_input_STB = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    add_input_STB = 1'b0;
    wait_out(lat, got, to);
    e = exp_q.pop_front();
    checks++;
    if (to || got !== e) begin errors++; $display("FAIL busy_ignore_sum: got %h expected %h", got, e); end
    @(posedge clk); #1;
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (add_output_STB || add_BUSY) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL busy_ignore_latched: active cycles %0d expected 0", seen); end
  endtask

`ifdef FP32_ADD_SUB_EN
  task automatic test_add_sub();
    int lat; logic [31:0] got; logic [31:0] e; bit to;
    exp_q.push_back(32'h40000000);
    launch(32'h40400000, 32'h3F800000, 1'b1);
    wait_out(lat, got, to);
    e = exp_q.pop_front();
    checks++;
    if (to || got !== e) begin errors++; $display("FAIL sub_op: got %h expected %h", got, e); end
    checks++;
    if (lat != 10) begin errors++; $display("FAIL sub_latency: got %0d expected 10", lat); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_reset_abort();
    test_busy_ignore();
`ifdef FP32_ADD_SUB_EN
    test_add_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
